// File: rtl/serial_frame_pkg.sv
// Shared types for the serial frame receiver: FSM state encoding and
// the bit-timing counter width helper.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rxState_t;

    function automatic int cntWidth(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous line that idles high;
// both stages reset to 1 so a reset never looks like a start edge.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Oversampling serial frame receiver with a one-word valid/ready holding
// register. Optional parity bit is compiled in with SERIAL_FRAME_RX_PARITY_EN.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DIV     = 16,
    parameter int PAR_ODD = 0
) (
    input  logic              CLK,
    input  logic              R,
    input  logic              gnd,
    input  logic              vdd,
    input  logic              RXD,
    output logic [DATA_W-1:0] DOUT,
    output logic              VALID,
    input  logic              READY,
    output logic              FERR,
    output logic              PERR,
    output logic              OVR,
    output logic              BUSY
);

    localparam int CW = cntWidth(DIV);
    localparam int BW = $clog2(DATA_W + 1);

    rxState_t          state;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     bitIdx;
    logic [DATA_W-1:0] shiftReg;
    logic              rxs;
    logic              rxsPrev;
    logic              done;
    logic              doneFerr;
    logic              doneParErr;
    logic              unusedPower;

    assign unusedPower = gnd ^ vdd;

    sync2 u_sync (
        .clk   (CLK),
        .rst_n (R),
        .d     (RXD),
        .q     (rxs)
    );

    assign BUSY = (state != IDLE);

`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic parBit;
    logic perrReg;
    assign PERR = perrReg;
`else
    assign PERR = 1'b0;
`endif

    // Bit-timing FSM: start is confirmed at mid-bit, later bits sampled
    // every DIV cycles; done pulses once per completed frame.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state      <= IDLE;
            cnt        <= '0;
            bitIdx     <= '0;
            shiftReg   <= '0;
            rxsPrev    <= 1'b1;
            done       <= 1'b0;
            doneFerr   <= 1'b0;
            doneParErr <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            parBit     <= 1'b0;
`endif
        end else begin
            rxsPrev <= rxs;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (rxsPrev && !rxs) begin
                        state <= START;
                        cnt   <= CW'(DIV / 2 - 1);
                    end
                end
                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (rxs) begin
                        state <= IDLE;
                    end else begin
                        state  <= DATA;
                        cnt    <= CW'(DIV - 1);
                        bitIdx <= '0;
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shiftReg <= {rxs, shiftReg[DATA_W-1:1]};
                        bitIdx   <= bitIdx + 1'b1;
                        cnt      <= CW'(DIV - 1);
                        if (bitIdx == BW'(DATA_W - 1)) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef SERIAL_FRAME_RX_PARITY_EN
                PARITY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        parBit <= rxs;
                        cnt    <= CW'(DIV - 1);
                        state  <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        done     <= 1'b1;
                        doneFerr <= !rxs;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        doneParErr <= ((^shiftReg) ^ parBit) != (PAR_ODD != 0);
`else
                        doneParErr <= 1'b0;
`endif
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Holding register: a finished frame loads if the slot is empty or
    // being drained this cycle, otherwise it is dropped with an OVR pulse.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            DOUT    <= '0;
            VALID   <= 1'b0;
            FERR    <= 1'b0;
            OVR     <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            perrReg <= 1'b0;
`endif
        end else begin
            OVR <= 1'b0;
            if (done && (!VALID || READY)) begin
                DOUT    <= shiftReg;
                FERR    <= doneFerr;
                VALID   <= 1'b1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                perrReg <= doneParErr;
`endif
            end else if (done) begin
                OVR <= 1'b1;
            end else if (VALID && READY) begin
                VALID <= 1'b0;
            end
        end
    end

`ifndef SERIAL_FRAME_RX_PARITY_EN
    logic unusedPar;
    assign unusedPar = doneParErr;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed self-checking bench for serial_frame_rx (DIV=16, DATA_W=8);
// parity cases run only when SERIAL_FRAME_RX_PARITY_EN is defined.
module tb_serial_frame_rx;

    localparam int DATA_W = 8;
    localparam int DIV    = 16;

    logic              CLK = 1'b0;
    logic              R = 1'b0;
    logic              gnd = 1'b0;
    logic              vdd = 1'b1;
    logic              RXD = 1'b1;
    logic [DATA_W-1:0] DOUT;
    logic              VALID;
    logic              READY = 1'b1;
    logic              FERR;
    logic              PERR;
    logic              OVR;
    logic              BUSY;

    int testsRun = 0;
    int testsFailed = 0;
    int acceptCount = 0;
    int validCycles = 0;
    int ovrCount = 0;
    logic [DATA_W-1:0] lastDout = '0;
    logic lastFerr = 1'b0;
    logic lastPerr = 1'b0;

    serial_frame_rx #(.DATA_W(DATA_W), .DIV(DIV), .PAR_ODD(0)) dut (
        .CLK   (CLK),
        .R     (R),
        .gnd   (gnd),
        .vdd   (vdd),
        .RXD   (RXD),
        .DOUT  (DOUT),
        .VALID (VALID),
        .READY (READY),
        .FERR  (FERR),
        .PERR  (PERR),
        .OVR   (OVR),
        .BUSY  (BUSY)
    );

    always #5 CLK = ~CLK;

    // Observe handshakes and overrun pulses away from the active edge.
    always @(negedge CLK) begin
        if (R) begin
            if (VALID) validCycles++;
            if (OVR) ovrCount++;
            if (VALID && READY) begin
                acceptCount++;
                lastDout = DOUT;
                lastFerr = FERR;
                lastPerr = PERR;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic sendBit(input logic b);
        @(posedge CLK);
        #1;
        RXD = b;
        repeat (DIV - 1) @(posedge CLK);
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] data, input logic stopBit, input logic parBit);
        sendBit(1'b0);
        for (int i = 0; i < DATA_W; i++) sendBit(data[i]);
`ifdef SERIAL_FRAME_RX_PARITY_EN
        sendBit(parBit);
`else
        if (parBit) begin end
`endif
        sendBit(stopBit);
    endtask

    int accBase;
    int ovrBase;
    int valBase;
    logic sawBusy;

    initial begin
        waitCycles(3);
        checkOutput("reset_dout", 32'(DOUT), 32'h0);
        checkOutput("reset_valid", 32'(VALID), 32'h0);
        checkOutput("reset_busy", 32'(BUSY), 32'h0);
        checkOutput("reset_flags", {29'h0, FERR, PERR, OVR}, 32'h0);
        R = 1'b1;
        waitCycles(4);

        // Clean frame with consumer ready
        accBase = acceptCount; ovrBase = ovrCount; valBase = validCycles;
        READY = 1'b1;
        applyStimulus(8'hA5, 1'b1, 1'b0);
        sendBit(1'b1);
        waitCycles(2 * DIV);
        checkOutput("a5_accepts", 32'(acceptCount - accBase), 32'd1);
        checkOutput("a5_valid_cycles", 32'(validCycles - valBase), 32'd1);
        checkOutput("a5_dout", 32'(lastDout), 32'hA5);
        checkOutput("a5_ferr", 32'(lastFerr), 32'h0);
        checkOutput("a5_ovr", 32'(ovrCount - ovrBase), 32'd0);
        checkOutput("a5_valid_low", 32'(VALID), 32'h0);

        // Short low glitch must be rejected in START
        accBase = acceptCount;
        sawBusy = 1'b0;
        @(posedge CLK); #1;
        RXD = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        RXD = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (BUSY) sawBusy = 1'b1;
        end
        waitCycles(2 * DIV);
        checkOutput("glitch_saw_busy", 32'(sawBusy), 32'h1);
        checkOutput("glitch_busy_idle", 32'(BUSY), 32'h0);
        checkOutput("glitch_no_valid", 32'(acceptCount - accBase), 32'd0);

        // Framing error, line held low afterwards
        accBase = acceptCount;
        applyStimulus(8'h3C, 1'b0, 1'b1);
        sawBusy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (i > 4 && BUSY) sawBusy = 1'b1;
        end
        checkOutput("ferr_dout", 32'(lastDout), 32'h3C);
        checkOutput("ferr_flag", 32'(lastFerr), 32'h1);
        checkOutput("ferr_no_restart", 32'(sawBusy), 32'h0);
        @(posedge CLK); #1;
        RXD = 1'b1;
        waitCycles(2 * DIV);
        checkOutput("ferr_accepts", 32'(acceptCount - accBase), 32'd1);
        checkOutput("ferr_idle_after_high", 32'(BUSY), 32'h0);

        // Overrun: consumer stalled across two frames
        accBase = acceptCount; ovrBase = ovrCount;
        READY = 1'b0;
        applyStimulus(8'h11, 1'b1, 1'b0);
        sendBit(1'b1);
        applyStimulus(8'h22, 1'b1, 1'b1);
        sendBit(1'b1);
        waitCycles(DIV);
        checkOutput("ovr_valid_held", 32'(VALID), 32'h1);
        checkOutput("ovr_dout_kept", 32'(DOUT), 32'h11);
        checkOutput("ovr_pulses", 32'(ovrCount - ovrBase), 32'd1);
        READY = 1'b1;
        waitCycles(3);
        checkOutput("ovr_drain_dout", 32'(lastDout), 32'h11);
        checkOutput("ovr_drain_count", 32'(acceptCount - accBase), 32'd1);
        checkOutput("ovr_drained", 32'(VALID), 32'h0);

        // Reset during bit 4 of a frame while a word is held
        READY = 1'b0;
        applyStimulus(8'h33, 1'b1, 1'b0);
        sendBit(1'b1);
        waitCycles(4);
        checkOutput("held_before_reset", 32'(DOUT), 32'h33);
        ovrBase = ovrCount;
        sendBit(1'b0);
        for (int i = 0; i < 4; i++) sendBit(1'(8'h5A >> i));
        @(posedge CLK); #1;
        RXD = 1'(8'h5A >> 4);
        repeat (DIV / 2) @(posedge CLK);
        #3;
        R = 1'b0;
        #1;
        checkOutput("rst_busy", 32'(BUSY), 32'h0);
        checkOutput("rst_valid", 32'(VALID), 32'h0);
        checkOutput("rst_dout", 32'(DOUT), 32'h0);
        checkOutput("rst_ovr", 32'(OVR), 32'h0);
        RXD = 1'b1;
        waitCycles(3);
        R = 1'b1;
        READY = 1'b1;
        waitCycles(4);
        accBase = acceptCount;
        applyStimulus(8'h5A, 1'b1, 1'b0);
        sendBit(1'b1);
        waitCycles(DIV);
        checkOutput("post_rst_accepts", 32'(acceptCount - accBase), 32'd1);
        checkOutput("post_rst_dout", 32'(lastDout), 32'h5A);
        checkOutput("post_rst_ferr", 32'(lastFerr), 32'h0);
        checkOutput("post_rst_ovr", 32'(ovrCount - ovrBase), 32'd0);

`ifdef SERIAL_FRAME_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so parity bit 1 is correct
        applyStimulus(8'h07, 1'b1, 1'b0);
        sendBit(1'b1);
        waitCycles(DIV);
        checkOutput("par_bad_dout", 32'(lastDout), 32'h07);
        checkOutput("par_bad_perr", 32'(lastPerr), 32'h1);
        applyStimulus(8'h07, 1'b1, 1'b1);
        sendBit(1'b1);
        waitCycles(DIV);
        checkOutput("par_good_perr", 32'(lastPerr), 32'h0);
`else
        checkOutput("perr_tied_low", 32'(lastPerr), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame (5..9).
REQ-002 SHALL have parameter DIV, default 16, CLK cycles per bit (even, >= 4).
REQ-003 SHALL have parameter PAR_ODD, default 0, parity sense: 0 = even, 1 = odd (used only with parity compiled in).
REQ-004 SHALL have port CLK  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port R  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports gnd, vdd  in  1 each  power ties; no functional effect.
REQ-007 SHALL have port RXD  in  1  asynchronous serial line, idle high, LSB first.
REQ-008 SHALL have port DOUT  out  DATA_W  received data word.
REQ-009 SHALL have port VALID  out  1  DOUT/FERR/PERR are held valid.
REQ-010 SHALL have port READY  in  1  consumer accepts the word when VALID&&READY.
REQ-011 SHALL have port FERR  out  1  stop bit sampled low; qualified by VALID.
REQ-012 SHALL have port PERR  out  1  parity mismatch; qualified by VALID.
REQ-013 SHALL have port OVR  out  1  one-cycle pulse: completed frame dropped.
REQ-014 SHALL have port BUSY  out  1  FSM not in IDLE.

Function
REQ-015 SHALL pass RXD through a 2-flop synchronizer (reset value 1); all FSM decisions use the synchronized value rxs.
REQ-016 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE -> START on an rxs falling edge (previous 1, current 0); the bit counter loads DIV/2-1.
REQ-018 START at count 0: if rxs=1, return to IDLE (glitch rejected, no output); else go to DATA with count DIV-1.
REQ-019 DATA SHALL sample rxs at count 0, shift it in LSB first, and reload DIV-1; after DATA_W samples go to PARITY if compiled in, else STOP.
REQ-020 STOP SHALL sample rxs at count 0, then return to IDLE in the next cycle; a low stop bit sets the frame FERR=1.
REQ-021 SHALL load the holding register (DOUT, FERR, PERR) and assert VALID in the cycle after the stop sample.
REQ-022 VALID SHALL deassert the cycle after VALID&&READY, unless a new frame loads in that same cycle, in which case VALID stays high with the new word.
REQ-023 If VALID=1 and READY=0 when a frame completes, SHALL keep the old word, drop the new one, and pulse OVR for one cycle.
REQ-024 After a low stop bit, SHALL require rxs=1 before the next start is detected (edge rule, REQ-017).
REQ-025 DOUT SHALL be stable while VALID=1 and READY=0.

Reset
REQ-026 R low SHALL asynchronously force FSM=IDLE, counters=0, synchronizer=1, DOUT=0, VALID=0, FERR=0, PERR=0, OVR=0, BUSY=0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no VALID or OVR.

Configuration
REQ-028 Macro SERIAL_FRAME_RX_PARITY_EN defined: the PARITY state samples one parity bit; PERR=1 when XOR(data, parity bit) differs from PAR_ODD.
REQ-029 Macro undefined: no PARITY state or parity logic; PERR is tied 0; frame length is 1+DATA_W+1 bits.

Structure
REQ-030 Package serial_frame_pkg SHALL hold the FSM state typedef and a function giving the counter width from DIV.
REQ-031 The synchronizer SHALL be sub-module sync2 (2 flops, async active-low reset to 1).

Verification
REQ-032 DIV=16, no parity: send 0xA5 with a good stop bit, READY=1 -> VALID for one cycle, DOUT=0xA5, FERR=0, OVR=0.
REQ-033 RXD low pulse of 5 cycles -> START rejects it, BUSY returns to 0, no VALID.
REQ-034 Send 0x3C with a low stop bit, then hold RXD low 40 cycles -> DOUT=0x3C, FERR=1, no second start until RXD goes high.
REQ-035 READY=0, send 0x11 then 0x22 -> DOUT stays 0x11, OVR pulses once at the end of the 0x22 frame.
REQ-036 PARITY_EN, PAR_ODD=0: send 0x07 with parity bit 0 -> PERR=1; with parity bit 1 -> PERR=0.
REQ-037 Assert R during bit 4 of a frame -> all outputs reach their reset values immediately; the next clean frame 0x5A is received correctly.
